// File: rtl/rx_shift_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_shift_unit_if
// Description : Bundles the serial input, framing strobes and the word
//               holding-register handshake of the receive shifter.
//               master = controller/consumer side, slave = shifter.
// Revision    : 1.0  initial release
// ============================================================================
interface rx_shift_unit_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);

    logic                  sda_in;
    logic                  rising_edge_found;
    logic                  rx_enable;
    logic                  frame_clear;
    logic                  data_read;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_overrun;
    logic [c_cnt_w-1:0]    bit_count;
    logic                  parity_err;

    modport master (
        output sda_in, rising_edge_found, rx_enable, frame_clear, data_read,
        input  rx_data, rx_valid, rx_overrun, bit_count, parity_err
    );

    modport slave (
        input  sda_in, rising_edge_found, rx_enable, frame_clear, data_read,
        output rx_data, rx_valid, rx_overrun, bit_count, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/rx_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : rx_shift_unit
// Description : Serial receive shifter. Samples sda_in on qualified SCL
//               rising edges, counts bits, and captures each completed word
//               into a holding register with valid/read handshake, sticky
//               overrun and frame abort. Optional even-parity bit per word
//               when RX_SHIFT_PARITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module rx_shift_unit #(
    parameter int DATA_WIDTH = 8,
    parameter bit SHIFT_MSB  = 1'b1
) (
    input  wire               clk,
    input  wire               n_rst,
    rx_shift_unit_if.slave    bus
);
    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);
`ifdef RX_SHIFT_PARITY_EN
    localparam int c_frame_len = DATA_WIDTH + 1;
`else
    localparam int c_frame_len = DATA_WIDTH;
`endif
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_frame_len - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_cnt_w-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_shift;
    logic                  w_last;
    logic                  w_data_bit;
    logic                  w_load;
    logic                  w_drop;
    logic                  w_unused;

    // frame_clear outranks a coincident edge strobe
    assign w_shift = bus.rx_enable & bus.rising_edge_found & ~bus.frame_clear;
    assign w_last  = w_shift & (r_count == c_last);

    // A completing word only lands if the holding register is free this cycle
    assign w_load  = w_last & (~r_valid | bus.data_read);
    assign w_drop  = w_last & r_valid & ~bus.data_read;

    generate
        if (SHIFT_MSB) begin : g_msb
            assign w_shifted = {r_shift[DATA_WIDTH-2:0], bus.sda_in};
        end else begin : g_lsb
            assign w_shifted = {bus.sda_in, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

`ifdef RX_SHIFT_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;

    // Final bit of the frame is parity: it is checked, never shifted in
    assign w_data_bit   = w_shift & ~w_last;
    assign w_word       = r_shift;
    assign w_parity_err = (^r_shift) ^ bus.sda_in;

    // Parity status travels with the held word
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)              r_parity_err <= 1'b0;
        else if (w_load)         r_parity_err <= w_parity_err;
        else if (bus.data_read)  r_parity_err <= 1'b0;
    end

    assign bus.parity_err = r_parity_err;
`else
    assign w_data_bit     = w_shift;
    assign w_word         = w_shifted;
    assign bus.parity_err = 1'b0;
`endif

    // The bit that falls out of the register on a shift is intentionally lost
    assign w_unused = ^r_shift;

    // Shift register idles at all ones (released bus); abort restores idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)               r_shift <= '1;
        else if (bus.frame_clear) r_shift <= '1;
        else if (w_data_bit)      r_shift <= w_shifted;
    end

    // Bit position within the frame, wrapping on completion
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)               r_count <= '0;
        else if (bus.frame_clear) r_count <= '0;
        else if (w_last)          r_count <= '0;
        else if (w_shift)         r_count <= r_count + c_cnt_w'(1);
    end

    // Holding register and its valid flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (bus.data_read) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun; a read always frees the register so it cannot re-set then
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)              r_overrun <= 1'b0;
        else if (w_drop)         r_overrun <= 1'b1;
        else if (bus.data_read)  r_overrun <= 1'b0;
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_overrun = r_overrun;
    assign bus.bit_count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_rx_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_shift_unit
// Description : Self-checking bench for rx_shift_unit. An MSB-first and an
//               LSB-first instance receive the same bit stream; expected
//               words are queued when a frame is driven and compared when
//               the holding register is loaded.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_shift_unit;
    logic clk;
    logic n_rst;
    int   n_total;
    int   n_bad;

    typedef struct {
        logic [7:0] msb_word;
        logic [7:0] lsb_word;
        logic       par_err;
    } exp_t;

    exp_t exp_q[$];

    rx_shift_unit_if #(.DATA_WIDTH(8)) if_msb ();
    rx_shift_unit_if #(.DATA_WIDTH(8)) if_lsb ();

    rx_shift_unit #(.DATA_WIDTH(8), .SHIFT_MSB(1'b1)) u_msb (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_msb)
    );

    rx_shift_unit #(.DATA_WIDTH(8), .SHIFT_MSB(1'b0)) u_lsb (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // One clock of stimulus to both instances; strobes drop after the edge
    task automatic cycle(input logic sda, input logic rise, input logic en,
                         input logic clr, input logic rd);
        @(negedge clk);
        if_msb.sda_in = sda;  if_msb.rising_edge_found = rise;
        if_msb.rx_enable = en; if_msb.frame_clear = clr; if_msb.data_read = rd;
        if_lsb.sda_in = sda;  if_lsb.rising_edge_found = rise;
        if_lsb.rx_enable = en; if_lsb.frame_clear = clr; if_lsb.data_read = rd;
        @(posedge clk);
        #1;
        if_msb.rising_edge_found = 1'b0; if_msb.frame_clear = 1'b0; if_msb.data_read = 1'b0;
        if_lsb.rising_edge_found = 1'b0; if_lsb.frame_clear = 1'b0; if_lsb.data_read = 1'b0;
    endtask

    // Sends val MSB-first on the wire (plus parity bit when enabled)
    task automatic send_frame(input logic [7:0] val, input logic par,
                              input logic rd_last, input logic exp_load);
        exp_t e;
        logic rd_data_last;
`ifdef RX_SHIFT_PARITY_EN
        rd_data_last = 1'b0;
`else
        rd_data_last = rd_last;
`endif
        if (exp_load) begin
            e.msb_word = val;
            e.lsb_word = rev8(val);
`ifdef RX_SHIFT_PARITY_EN
            e.par_err  = (^val) ^ par;
`else
            e.par_err  = 1'b0;
`endif
            exp_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--)
            cycle(val[i], 1'b1, 1'b1, 1'b0, (i == 0) ? rd_data_last : 1'b0);
`ifdef RX_SHIFT_PARITY_EN
        cycle(par, 1'b1, 1'b1, 1'b0, rd_last);
`endif
        check("count_wrap", 32'(if_msb.bit_count), 32'd0);
        if (exp_load) begin
            if (exp_q.size() == 0) begin
                check("queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("valid_load", 32'(if_msb.rx_valid), 32'd1);
                check("msb_data", 32'(if_msb.rx_data), 32'(e.msb_word));
                check("lsb_data", 32'(if_lsb.rx_data), 32'(e.lsb_word));
                check("parity_err", 32'(if_msb.parity_err), 32'(e.par_err));
            end
        end
    endtask

    task automatic read_word();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("valid_after_read", 32'(if_msb.rx_valid), 32'd0);
        check("ovr_after_read", 32'(if_msb.rx_overrun), 32'd0);
        check("par_after_read", 32'(if_msb.parity_err), 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_rst   = 1'b0;
        if_msb.sda_in = 1'b0; if_msb.rising_edge_found = 1'b0; if_msb.rx_enable = 1'b1;
        if_msb.frame_clear = 1'b0; if_msb.data_read = 1'b0;
        if_lsb.sda_in = 1'b0; if_lsb.rising_edge_found = 1'b0; if_lsb.rx_enable = 1'b1;
        if_lsb.frame_clear = 1'b0; if_lsb.data_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(if_msb.rx_data), 32'd0);
        check("rst_valid", 32'(if_msb.rx_valid), 32'd0);
        check("rst_ovr", 32'(if_msb.rx_overrun), 32'd0);
        check("rst_count", 32'(if_msb.bit_count), 32'd0);
        check("rst_par", 32'(if_msb.parity_err), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Palindrome stream 1,0,1,0,0,1,0,1
        send_frame(8'hA5, ^8'hA5, 1'b0, 1'b1);
        check("ovr_clean", 32'(if_msb.rx_overrun), 32'd0);
        read_word();
        // Read with nothing held is ignored
        read_word();

        // Stream 1,0,0,0,0,0,0,0: 0x80 MSB-first, 0x01 LSB-first
        send_frame(8'h80, ^8'h80, 1'b0, 1'b1);
        read_word();

        // Overrun: second word dropped, first retained
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, ^8'hC3, 1'b0, 1'b0);
        check("ovr_data_kept", 32'(if_msb.rx_data), 32'h3C);
        check("ovr_flag", 32'(if_msb.rx_overrun), 32'd1);
        check("ovr_valid", 32'(if_msb.rx_valid), 32'd1);
        read_word();

        // Frame abort after 5 bits, coincident with an edge strobe
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("partial_count", 32'(if_msb.bit_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clear_count", 32'(if_msb.bit_count), 32'd0);
        check("clear_valid", 32'(if_msb.rx_valid), 32'd0);
        send_frame(8'h7E, ^8'h7E, 1'b0, 1'b1);

        // Completion coincident with reading the prior word
        send_frame(8'h11, ^8'h11, 1'b1, 1'b1);
        check("sim_ovr", 32'(if_msb.rx_overrun), 32'd0);
        read_word();

        // Edges while disabled leave the count alone
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_dis_count", 32'(if_msb.bit_count), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dis_count", 32'(if_msb.bit_count), 32'd3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_only_count", 32'(if_msb.bit_count), 32'd0);

`ifdef RX_SHIFT_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check("par_bad", 32'(if_msb.parity_err), 32'd1);
        read_word();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("par_good", 32'(if_msb.parity_err), 32'd0);
        read_word();
`endif

        // Asynchronous reset mid-word with a word held
        send_frame(8'h5A, ^8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_count", 32'(if_msb.bit_count), 32'd4);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_data", 32'(if_msb.rx_data), 32'd0);
        check("arst_valid", 32'(if_msb.rx_valid), 32'd0);
        check("arst_count", 32'(if_msb.bit_count), 32'd0);
        check("arst_ovr", 32'(if_msb.rx_overrun), 32'd0);
        check("arst_lsb_data", 32'(if_lsb.rx_data), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        send_frame(8'hC5, ^8'hC5, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
